playlist_sequencer: RTL and testbench

Top-level sequencing controller for the music player. Owns the song selection and the play/pause intent, and drives song_reader's play and song inputs. Issues a one-cycle flush pulse to song_reader and the note player on every song change. Auto-advances to the next song on song completion, with an optional silent gap between songs.

---
 rtl/playlist_sequencer_pkg.sv | 24 ++
 rtl/playlist_sequencer_rise_detect.sv | 29 ++
 rtl/playlist_sequencer.sv | 153 +++++++++++++++
 tb/tb_playlist_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/playlist_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// playlist_sequencer_pkg
// Shared player definitions: sequencer state encodings, default song count,
// song index width and the wrapping song-increment helper.
// -----------------------------------------------------------------------------
package playlist_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_PAUSED  = 2'b00,
    ST_PLAYING = 2'b01,
    ST_FLUSH   = 2'b10,
    ST_GAP     = 2'b11
  } state_e;

  localparam int DEFAULT_NUM_SONGS = 4;
  localparam int SONG_W            = 2;

  // Next song index, wrapping after the last song in the ROM.
  function automatic logic [SONG_W-1:0] song_inc(input logic [SONG_W-1:0] s,
                                                 input int num_songs);
    return (int'(s) == num_songs - 1) ? '0 : s + SONG_W'(1);
  endfunction

endpackage

// File: rtl/playlist_sequencer_rise_detect.sv
// -----------------------------------------------------------------------------
// playlist_sequencer_rise_detect
// One-flop rising-edge detector. A level held high produces a single pulse.
//   clk    : system clock
//   reset  : asynchronous active-high reset (history cleared to 0)
//   sig_i  : level input
//   rise_o : high for the cycle in which sig_i is 1 and was 0 last cycle
// -----------------------------------------------------------------------------
module playlist_sequencer_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_d, sig_q;

  assign sig_d = sig_i;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sig_q <= 1'b0;
    else       sig_q <= sig_d;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/playlist_sequencer.sv
// -----------------------------------------------------------------------------
// playlist_sequencer
// Song selection and play/pause controller for the music player. Drives the
// song_reader play/song inputs, emits a one-cycle flush pulse on every song
// change and auto-advances on song completion with an optional silent gap.
//
// Configuration macro:
//   PLAYLIST_LOOP_EN : defined  -> finishing the last song wraps to song 0 and
//                                  keeps playing (gap applies)
//                      undefined-> finishing the last song selects song 0,
//                                  flushes and stops in PAUSED
//
// Ports:
//   clk          : system clock
//   reset        : asynchronous active-high reset
//   play_button  : one-cycle pulse, toggles play/pause
//   next_button  : one-cycle pulse, skip to next song (always wraps)
//   song_done    : level from song_reader, only its rising edge is used
//   play         : high only in PLAYING
//   song         : current song index
//   reset_player : one-cycle flush pulse (FLUSH state)
//   busy         : high in FLUSH or GAP
// -----------------------------------------------------------------------------
module playlist_sequencer
  import playlist_sequencer_pkg::*;
#(
  parameter int NUM_SONGS  = DEFAULT_NUM_SONGS,
  parameter int GAP_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              song_done,
  output logic              play,
  output logic [SONG_W-1:0] song,
  output logic              reset_player,
  output logic              busy
);

  localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
`ifdef PLAYLIST_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  state_e            state_d, state_q;
  logic [SONG_W-1:0] song_d, song_q;
  logic              resume_d, resume_q;  // play again after the flush
  logic              auto_d, auto_q;      // flush came from auto-advance
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              done_rise;

  playlist_sequencer_rise_detect u_done_rise (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (song_done),
    .rise_o (done_rise)
  );

  // NOTE: every variable gets a hold-value default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d  = state_q;
    song_d   = song_q;
    resume_d = resume_q;
    auto_d   = auto_q;
    cnt_d    = cnt_q;
    // Priority in every state: next_button > done_rise > play_button.
    case (state_q)
      ST_PAUSED: begin
        if (next_button) begin
          song_d   = song_inc(song_q, NUM_SONGS);
          resume_d = 1'b0;
          auto_d   = 1'b0;
          state_d  = ST_FLUSH;
        end else if (play_button) begin
          state_d = ST_PLAYING;
        end
      end
      ST_PLAYING: begin
        if (next_button) begin
          song_d   = song_inc(song_q, NUM_SONGS);
          resume_d = 1'b1;
          auto_d   = 1'b0;
          state_d  = ST_FLUSH;
        end else if (done_rise) begin
          if (song_q == LAST_SONG && !LOOP_EN) begin
            song_d   = '0;
            resume_d = 1'b0;
            auto_d   = 1'b0;
          end else begin
            song_d   = song_inc(song_q, NUM_SONGS);
            resume_d = 1'b1;
            auto_d   = 1'b1;
          end
          state_d = ST_FLUSH;
        end else if (play_button) begin
          state_d = ST_PAUSED;
        end
      end
      ST_FLUSH: begin
        if (auto_q && GAP_CYCLES > 0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          state_d = resume_q ? ST_PLAYING : ST_PAUSED;
        end
      end
      ST_GAP: begin
        if (next_button) begin
          song_d   = song_inc(song_q, NUM_SONGS);
          resume_d = 1'b1;
          auto_d   = 1'b0;
          state_d  = ST_FLUSH;
        end else if (play_button) begin
          state_d = ST_PAUSED;  // gap cancelled, new song kept
        end else if (cnt_q == '0) begin
          state_d = ST_PLAYING;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_PAUSED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_PAUSED;
      song_q   <= '0;
      resume_q <= 1'b0;
      auto_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      song_q   <= song_d;
      resume_q <= resume_d;
      auto_q   <= auto_d;
      cnt_q    <= cnt_d;
    end
  end

  // Moore outputs decoded straight from the state register.
  assign play         = (state_q == ST_PLAYING);
  assign reset_player = (state_q == ST_FLUSH);
  assign busy         = (state_q == ST_FLUSH) || (state_q == ST_GAP);
  assign song         = song_q;

endmodule

// File: tb/tb_playlist_sequencer.sv
// -----------------------------------------------------------------------------
// tb_playlist_sequencer
// Directed bench for playlist_sequencer. A timeline model (song, play intent,
// absolute cycle numbers of the flush and of the end of the busy window) is
// compared against the DUT on every cycle; literal checks pin key moments.
// -----------------------------------------------------------------------------
module tb_playlist_sequencer;

  localparam int NUM = 4;
  localparam int GAP = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       play_button = 1'b0;
  logic       next_button = 1'b0;
  logic       song_done = 1'b0;
  logic       play;
  logic [1:0] song;
  logic       reset_player;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  playlist_sequencer #(.NUM_SONGS(NUM), .GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .reset        (reset),
    .play_button  (play_button),
    .next_button  (next_button),
    .song_done    (song_done),
    .play         (play),
    .song         (song),
    .reset_player (reset_player),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
`ifdef PLAYLIST_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  int m_cyc, m_flush_cyc, m_busy_end, m_song;
  bit m_playing, m_prev_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cyc       <= 0;
      m_flush_cyc <= -100;
      m_busy_end  <= -100;
      m_song      <= 0;
      m_playing   <= 1'b0;
      m_prev_done <= 1'b0;
    end else begin : upd
      int  old;
      bit  rise, in_flush, in_gap;
      old      = m_cyc;
      rise     = song_done && !m_prev_done;
      in_flush = (old == m_flush_cyc);
      in_gap   = (old > m_flush_cyc) && (old <= m_busy_end);
      m_prev_done <= song_done;
      if (!in_flush) begin
        if (next_button) begin
          m_song      <= (m_song + 1) % NUM;
          m_flush_cyc <= old + 1;
          m_busy_end  <= old + 1;
          // play intent is kept: skipping from PAUSED stays paused
        end else if (rise && m_playing && !in_gap) begin
          m_flush_cyc <= old + 1;
          if (m_song == NUM - 1 && !LOOP) begin
            m_song     <= 0;
            m_playing  <= 1'b0;
            m_busy_end <= old + 1;
          end else begin
            m_song     <= (m_song + 1) % NUM;
            m_busy_end <= old + 1 + GAP;
          end
        end else if (play_button) begin
          if (in_gap) begin
            m_playing  <= 1'b0;
            m_busy_end <= old;
          end else begin
            m_playing <= !m_playing;
          end
        end
      end
      m_cyc <= old + 1;
    end
  end

  always @(negedge clk) begin
    bit e_busy;
    e_busy = (m_cyc >= m_flush_cyc) && (m_cyc <= m_busy_end);
    check("model_play", play, m_playing && (m_cyc > m_busy_end));
    check("model_song", song, m_song);
    check("model_reset_player", reset_player, m_cyc == m_flush_cyc);
    check("model_busy", busy, e_busy);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit nb, input bit pb);
    @(negedge clk);
    next_button = nb;
    play_button = pb;
    @(negedge clk);
    next_button = 1'b0;
    play_button = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc_wait(3);
    check("rst_play", play, 0);
    check("rst_song", song, 0);
    check("rst_reset_player", reset_player, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    cyc_wait(1);

    pulse(0, 1);
    check("pb_play", play, 1);

    pulse(1, 0);
    check("skip_rp", reset_player, 1);
    check("skip_song", song, 1);
    check("skip_play_low", play, 0);
    cyc_wait(1);
    check("skip_resume", play, 1);

    // Auto-advance from song 1 with a 16-cycle gap.
    @(negedge clk);
    song_done = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (i == 1) begin
        song_done = 1'b0;
        check("adv_song", song, 2);
        check("adv_rp", reset_player, 1);
        check("adv_play_low", play, 0);
      end
      if (i == 2 || i == 17) begin
        check("adv_gap_busy", busy, 1);
        check("adv_gap_rp", reset_player, 0);
      end
      if (i == 18) begin
        check("adv_play", play, 1);
        check("adv_busy_low", busy, 0);
      end
    end

    pulse(1, 0);
    cyc_wait(1);
    check("song3", song, 3);

    // Completion of the last song.
    @(negedge clk);
    song_done = 1'b1;
    @(negedge clk);
    song_done = 1'b0;
    check("last_song0", song, 0);
    check("last_rp", reset_player, 1);
`ifdef PLAYLIST_LOOP_EN
    cyc_wait(17);
    check("last_loop_play", play, 1);
`else
    cyc_wait(1);
    check("last_stop_play", play, 0);
    check("last_stop_busy", busy, 0);
    cyc_wait(2);
    check("last_stop_hold", play, 0);
`endif
    if (m_playing) pulse(0, 1);
    cyc_wait(1);

    // Paused skips up to song 3, then wrap to 0 while paused.
    repeat (3) begin
      pulse(1, 0);
      cyc_wait(1);
    end
    check("paused_song3", song, 3);
    pulse(1, 0);
    check("paused_wrap_song", song, 0);
    check("paused_wrap_rp", reset_player, 1);
    cyc_wait(1);
    check("paused_wrap_play", play, 0);
    song_done = 1'b1;
    cyc_wait(50);
    song_done = 1'b0;
    check("held_done_song", song, 0);
    check("held_done_play", play, 0);
    check("held_done_busy", busy, 0);

    // next and play in the same cycle: skip wins.
    pulse(0, 1);
    check("play_again", play, 1);
    pulse(1, 1);
    check("both_rp", reset_player, 1);
    check("both_song", song, 1);
    cyc_wait(1);
    check("both_play", play, 1);

    // Cancel the gap with play_button at count 5.
    @(negedge clk);
    song_done = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      if (i == 1) song_done = 1'b0;
      if (i == 12) play_button = 1'b1;
      if (i == 13) play_button = 1'b0;
    end
    check("cancel_play", play, 0);
    check("cancel_busy", busy, 0);
    check("cancel_song", song, 2);
    cyc_wait(3);
    check("cancel_hold", play, 0);
    pulse(0, 1);
    check("cancel_resume", play, 1);
    check("cancel_no_flush", reset_player, 0);

    // Async reset in the middle of a gap.
    @(negedge clk);
    song_done = 1'b1;
    @(negedge clk);
    song_done = 1'b0;
    cyc_wait(5);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_play", play, 0);
    check("midrst_song", song, 0);
    check("midrst_rp", reset_player, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc_wait(5);
    check("post_rst_busy", busy, 0);
    check("post_rst_rp", reset_player, 0);
    pulse(0, 1);
    check("post_rst_play", play, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
